mem_arbiter: RTL
================

# mem_arbiter

Two-port round-robin arbiter that shares the single `mem` bus port (ROM/IO/RAM1/DRAM) between two requesters, e.g. CPU (port 0) and a DMA/video fetch engine (port 1). It sits between the requesters and `mem`. It sequences each access as ACCESS then RESP, stretches ACCESS while `mem_wait` is high, and returns the read data with a one-cycle acknowledge.

## Interface
- `ADDR_WIDTH`, default 32, byte address width.
- `DATA_WIDTH`, default 32, data word width.

- `clk`  in  1  system clock; all state changes on its rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `m0_req`, `m1_req`  in  1  access request; held with addr/we/wdata until the matching ack
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read
- `m0_addr`, `m1_addr`  in  ADDR_WIDTH  byte address
- `m0_wdata`, `m1_wdata`  in  DATA_WIDTH  write data
- `m0_rdata`, `m1_rdata`  out  DATA_WIDTH  read data; valid only while the matching ack is high
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse
- `mem_addr`  out  ADDR_WIDTH  to `mem` addr
- `mem_data_in`  out  DATA_WIDTH  to `mem` data_in
- `mem_read_enable`, `mem_write_enable`  out  1  to `mem`
- `mem_data_out`  in  DATA_WIDTH  from `mem` data_out
- `mem_wait`  in  1  from `mem`; high = access not yet accepted

## Operation
- State register: IDLE, ACCESS, RESP.
- Registered `gnt` (0/1) selects the owning port. Registered `last` holds the port served most recently.
- **Arbitration**, performed in IDLE, and in RESP for the non-owning port only:
  - One request pending: grant it.
  - Both pending: grant `!last` (round-robin).
  - On grant: `gnt` <= winner, `last` <= winner, next state ACCESS.
- **IDLE**: all `mem_*` enables low. Stay in IDLE if no request is pending.
- **ACCESS**:
  - `mem_addr`/`mem_data_in` = granted port's addr/wdata (mux on `gnt`).
  - `mem_read_enable` = !we; `mem_write_enable` = we.
  - `mem_wait`=1: remain in ACCESS with outputs held.
  - `mem_wait`=0: next state RESP.
- **RESP**:
  - Enables low. `mem_addr` still driven from the granted port.
  - `mN_ack` = (state==RESP && gnt==N), decoded from registers only.
  - Both `mN_rdata` = `mem_data_out` (pass-through). For writes the rdata value is don't-care.
  - Next state:
    - If the other port is requesting: grant it directly (ACCESS).
    - Otherwise: IDLE.
    - The just-served port's req is ignored in RESP, because its req may still be high in the ack cycle.
- Enables are never both high. No enable is asserted outside ACCESS.
- A requester dropping req during ACCESS is illegal. The arbiter completes the access anyway.

## Timing
- **Reset** (`rst_n`=0 at an edge), taking effect at any state including mid-ACCESS:
  - state=IDLE, gnt=0, last=1, so port 0 wins the first tie.
  - Both acks 0, both enables 0; `mem_addr`/`mem_data_in` = port 0 inputs.
  - An access abandoned by reset gives no ack.
- **Single access with `mem_wait`=0**:
  - Cycle 0: IDLE sees req.
  - Cycle 1: ACCESS, enable high.
  - Cycle 2: RESP, ack high, rdata valid.
  - Latency 2 cycles from the req-sampled edge to ack.
- **`mem_wait`**: each cycle of `mem_wait`=1 in ACCESS adds exactly one cycle.
- **Throughput**:
  - Alternating ports: one access every 2 cycles (ACCESS, RESP, ACCESS, …).
  - Same port repeatedly: one access every 3 cycles (IDLE gap).
- **Requester rules**:
  - Sample ack/rdata at the clock edge ending the ack cycle.
  - Req may stay high into IDLE to request again; it is then arbitrated normally.
- **`mem` contract**:
  - Read data is valid the cycle after the accepting edge.
  - `mem` changes its output select only when `read_enable` is high, so `mem_data_out` is stable throughout RESP.

## Test plan
- Reset, then port0 read of 0x00001000, `mem` returns 0xDEADBEEF next cycle -> `mem_read_enable`=1 in cycle 1 only, `m0_ack`=1 with `m0_rdata`=0xDEADBEEF in cycle 2, `m1_ack` never set.
- Both ports raise req in the same cycle after reset, reads held continuously -> grant order 0,1,0,1. Acks alternate every 2 cycles after the first. The enables never overlap.
- Port1 write of 0x12345678 to 0x00010000 with `mem_wait` high for 3 cycles -> `mem_write_enable` high for 4 cycles with stable addr/data, `m1_ack` on the 5th cycle after grant.
- Port0 held requesting continuously alone -> ACCESS, RESP, IDLE repeating, one `m0_ack` every 3 cycles. Port1 raising req in a port0 RESP cycle goes straight to ACCESS next cycle.
- `rst_n` low during ACCESS with `mem_wait`=1 -> next cycle IDLE, enables 0, no ack. The first tie after reset is granted to port 0.
- Port0 write followed by port0 read of the same address 0x00002000, data 0xA5A5A5A5 -> read ack returns 0xA5A5A5A5.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the shared mem port seen by mem_arbiter.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  m0_req;
    logic                  m0_we;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic [DATA_WIDTH-1:0] m0_rdata;
    logic                  m0_ack;

    logic                  m1_req;
    logic                  m1_we;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic [DATA_WIDTH-1:0] m1_rdata;
    logic                  m1_ack;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  mem_read_enable;
    logic                  mem_write_enable;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  mem_wait;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m0_rdata, m0_ack, m1_rdata, m1_ack,
        output mem_addr, mem_data_in, mem_read_enable, mem_write_enable,
        input  mem_data_out, mem_wait
    );

    // Requester and memory side
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m0_rdata, m0_ack, m1_rdata, m1_ack,
        input  mem_addr, mem_data_in, mem_read_enable, mem_write_enable,
        output mem_data_out, mem_wait
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one mem port; each access runs ACCESS then RESP.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   gnt;
    logic   gnt_next;
    logic   last;
    logic   last_next;
    logic   win;
    logic   other_req;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_we;

    // State, owning port and most-recently-served port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            gnt   <= gnt_next;
            last  <= last_next;
        end
    end

    // Arbitration and sequencing; in RESP only the non-owning port may be granted
    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        last_next  = last;
        win        = (bus.m0_req && bus.m1_req) ? ~last : bus.m1_req;
        other_req  = gnt ? bus.m0_req : bus.m1_req;
        unique case (state)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    state_next = ACCESS;
                    gnt_next   = win;
                    last_next  = win;
                end
            end
            ACCESS: begin
                if (!bus.mem_wait) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (other_req) begin
                    state_next = ACCESS;
                    gnt_next   = ~gnt;
                    last_next  = ~gnt;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus mux on the owner, enables only in ACCESS, acks decoded from registers
    always_comb begin
        sel_addr             = gnt ? bus.m1_addr  : bus.m0_addr;
        sel_wdata            = gnt ? bus.m1_wdata : bus.m0_wdata;
        sel_we               = gnt ? bus.m1_we    : bus.m0_we;
        bus.mem_addr         = sel_addr;
        bus.mem_data_in      = sel_wdata;
        bus.mem_read_enable  = 1'b0;
        bus.mem_write_enable = 1'b0;
        bus.m0_ack           = (state == RESP) && !gnt;
        bus.m1_ack           = (state == RESP) && gnt;
        bus.m0_rdata         = bus.mem_data_out;
        bus.m1_rdata         = bus.mem_data_out;
        if (state == ACCESS) begin
            bus.mem_read_enable  = !sel_we;
            bus.mem_write_enable = sel_we;
        end
    end
endmodule
